// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  localparam int MEM_DATA_W_DEF  = 16;
  localparam int MEM_ADDR_W_DEF  = 10;
  localparam int MEM_REQ_ADDR_W  = 16;
  localparam int MEM_LATENCY_MAX = 15;
  localparam int MEM_CNT_W       = $clog2(MEM_LATENCY_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor memory port and the responder.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W_DEF
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [MEM_REQ_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with write enable and registered read data.
// A write also returns the written word on rdata. Storage is not reset; only
// the read register is.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W_DEF,
  parameter int ADDR_W = MEM_ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // storage update, only on an enabled write
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // read register: captures the accessed word, held until the next access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder with configurable access latency (1..MEM_LATENCY_MAX).
// Optional feature macro: MEM_ADDR_CHECK_EN -- flags requests whose address
// has bits set above the array index range; such requests return rsp_err=1,
// rsp_rdata=0 and never write the array. Without it, addresses alias.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request latched, counting down wait states
//   RESP  | response presented, held until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = MEM_DATA_W_DEF,
  parameter int ADDR_W  = MEM_ADDR_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  // The accepting edge counts as the first latency cycle and the access edge
  // as the last, so WAIT spans LATENCY-1 edges; the counter starts at LATENCY-2.
  localparam logic [MEM_CNT_W-1:0] CNT_LOAD =
    (LATENCY > 1) ? MEM_CNT_W'(LATENCY - 2) : '0;

  mem_state_t                state, state_nxt;
  logic [MEM_CNT_W-1:0]      cnt;
  logic                      accept;
  logic                      acc_fire;

  logic                      wr_q;
  logic [MEM_REQ_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]         wdata_q;

  logic                      acc_write;
  logic [MEM_REQ_ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0]         acc_wdata;
  logic                      addr_err;
  logic                      err_q;
  logic [DATA_W-1:0]         arr_rdata;

  assign accept = (state == IDLE) && bus.req_valid;

  // With single-cycle latency the access happens on the accepting edge, so
  // it must use the live request rather than the latched copy.
  assign acc_write = (LATENCY == 1) ? bus.req_write : wr_q;
  assign acc_addr  = (LATENCY == 1) ? bus.req_addr  : addr_q;
  assign acc_wdata = (LATENCY == 1) ? bus.req_wdata : wdata_q;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = |acc_addr[MEM_REQ_ADDR_W-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign addr_err       = 1'b0;
  assign unused_addr_hi = |acc_addr[MEM_REQ_ADDR_W-1:ADDR_W];
`endif

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and access-edge decode
  always_comb begin
    state_nxt = state;
    acc_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            acc_fire  = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          acc_fire  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs, decoded from state only
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE);
  end

  // wait-state down-counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // request capture on acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // error flag captured on the access edge, stable through RESP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (acc_fire) begin
      err_q <= addr_err;
    end
  end

  // An erroring access never enables the array, so it cannot write it.
  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .en    (acc_fire && !addr_err),
    .we    (acc_write),
    .addr  (acc_addr[ADDR_W-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign bus.rsp_rdata = err_q ? '0 : arr_rdata;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with LATENCY 1, 2 and 15
// share one clock and reset; each is driven through its own interface.
module tb_mem_responder;

  logic        clock;
  logic        reset;

  logic [2:0]  req_valid, req_write, rsp_ready;
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic [2:0]  req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata [3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 15;
    mem_responder_if #(.DATA_W(16)) bus ();
    assign bus.req_valid    = req_valid[g];
    assign bus.req_write    = req_write[g];
    assign bus.req_addr     = req_addr[g];
    assign bus.req_wdata    = req_wdata[g];
    assign bus.rsp_ready    = rsp_ready[g];
    assign req_ready[g]     = bus.req_ready;
    assign rsp_valid[g]     = bus.rsp_valid;
    assign rsp_rdata[g]     = bus.rsp_rdata;
    assign rsp_err[g]       = bus.rsp_err;
    assign busy[g]          = bus.busy;
    mem_responder #(.DATA_W(16), .ADDR_W(10), .LATENCY(LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );
  end

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, " req_ready"}, 32'(req_ready[i]), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid[i]), 32'd0);
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata[i]), 32'd0);
    chk({tag, " rsp_err"},   32'(rsp_err[i]),   32'd0);
    chk({tag, " busy"},      32'(busy[i]),      32'd0);
  endtask

  // One full transaction with rsp_ready=1. lat counts edges from the accepting
  // edge up to the edge after which rsp_valid is seen, inclusive.
  task automatic xact(input int i, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wd, output logic [15:0] rd,
                      output logic er, output int lat);
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    rsp_ready[i] = 1'b1;
    req_valid[i] = 1'b1;
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
    lat = 1;
    while (!rsp_valid[i] && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(posedge clock); #1;
  endtask

  // Hold a read request continuously and measure edges between two accepts.
  task automatic spacing(input int i, output int gap);
    int  edge_n, accepts, first, second, guard;
    logic rdy_prev;
    edge_n = 0; accepts = 0; first = 0; second = 0;
    req_write[i] = 1'b0;
    req_addr[i]  = 16'h0005;
    rsp_ready[i] = 1'b1;
    req_valid[i] = 1'b1;
    rdy_prev = req_ready[i];
    while (accepts < 2 && edge_n < 100) begin
      @(posedge clock); #1;
      edge_n++;
      if (rdy_prev) begin
        accepts++;
        if (accepts == 1) first = edge_n;
        else second = edge_n;
      end
      rdy_prev = req_ready[i];
    end
    req_valid[i] = 1'b0;
    gap = (accepts == 2) ? (second - first) : -1;
    guard = 0;
    while (busy[i] && guard < 40) begin
      @(posedge clock); #1;
      guard++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, gap, guard;

    clock     = 1'b0;
    reset     = 1'b0;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end

    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals(1, "por");
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // LATENCY=2: fill 0x0005, then read it back
    xact(1, 1'b1, 16'h0005, 16'hA5A5, rd, er, lat);
    chk("l2 wr5 lat", 32'(lat), 32'd2);
    chk("l2 wr5 rdata", 32'(rd), 32'hA5A5);
    xact(1, 1'b0, 16'h0005, 16'h0000, rd, er, lat);
    chk("l2 rd5 lat", 32'(lat), 32'd2);
    chk("l2 rd5 rdata", 32'(rd), 32'hA5A5);
    chk("l2 rd5 err", 32'(er), 32'd0);

    // write BEEF to 0x0010 then read it
    xact(1, 1'b1, 16'h0010, 16'hBEEF, rd, er, lat);
    chk("l2 wr10 rdata", 32'(rd), 32'hBEEF);
    xact(1, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
    chk("l2 rd10 rdata", 32'(rd), 32'hBEEF);
    chk("l2 idle after rsp", 32'(req_ready[1]), 32'd1);

    // response held off by rsp_ready=0 for 5 cycles, new request pending
    rsp_ready[1] = 1'b0;
    req_write[1] = 1'b0;
    req_addr[1]  = 16'h0010;
    req_valid[1] = 1'b1;
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    guard = 0;
    while (!rsp_valid[1] && guard < 40) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("hold rsp_valid up", 32'(rsp_valid[1]), 32'd1);
    req_addr[1]  = 16'h0005;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("hold%0d rsp_rdata", c), 32'(rsp_rdata[1]), 32'hBEEF);
      chk($sformatf("hold%0d req_ready", c), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clock); #1;
    chk("hold handshake req_ready", 32'(req_ready[1]), 32'd1);
    chk("hold handshake busy", 32'(busy[1]), 32'd0);
    @(posedge clock); #1;
    chk("hold new req accepted", 32'(busy[1]), 32'd1);
    req_valid[1] = 1'b0;
    guard = 0;
    while (!rsp_valid[1] && guard < 40) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("hold new req rdata", 32'(rsp_rdata[1]), 32'hA5A5);
    @(posedge clock); #1;

    // LATENCY=1: live-signal access
    xact(0, 1'b1, 16'h0033, 16'h7E7E, rd, er, lat);
    chk("l1 wr lat", 32'(lat), 32'd1);
    chk("l1 wr rdata", 32'(rd), 32'h7E7E);
    xact(0, 1'b0, 16'h0033, 16'h0000, rd, er, lat);
    chk("l1 rd rdata", 32'(rd), 32'h7E7E);

    // back-to-back spacing
    spacing(0, gap);
    chk("l1 spacing", 32'(gap), 32'd2);
    spacing(2, gap);
    chk("l15 spacing", 32'(gap), 32'd16);

    // LATENCY=15: preload 0x0020, then reset mid-WAIT during a write
    xact(2, 1'b1, 16'h0020, 16'h5555, rd, er, lat);
    chk("l15 wr lat", 32'(lat), 32'd15);
    chk("l15 wr rdata", 32'(rd), 32'h5555);
    req_write[2] = 1'b1;
    req_addr[2]  = 16'h0020;
    req_wdata[2] = 16'h1234;
    req_valid[2] = 1'b1;
    @(posedge clock); #1;
    req_valid[2] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("l15 in wait busy", 32'(busy[2]), 32'd1);
    chk("l15 in wait rsp_valid", 32'(rsp_valid[2]), 32'd0);
    reset = 1'b0;
    #2;
    chk_reset_vals(2, "wait rst");
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    xact(2, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
    chk("l15 rd after rst", 32'(rd), 32'h5555);

    // out-of-range address: 0x0400 aliases to 0x000 unless checked
    xact(1, 1'b1, 16'h0000, 16'h1111, rd, er, lat);
    chk("l2 wr0 rdata", 32'(rd), 32'h1111);
    xact(1, 1'b1, 16'h0400, 16'h2222, rd, er, lat);
    chk("l2 wr400 lat", 32'(lat), 32'd2);
`ifdef MEM_ADDR_CHECK_EN
    chk("l2 wr400 err", 32'(er), 32'd1);
    chk("l2 wr400 rdata", 32'(rd), 32'h0000);
    xact(1, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
    chk("l2 rd0 after bad wr", 32'(rd), 32'h1111);
`else
    chk("l2 wr400 err", 32'(er), 32'd0);
    chk("l2 wr400 rdata", 32'(rd), 32'h2222);
    xact(1, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
    chk("l2 rd0 after alias wr", 32'(rd), 32'h2222);
`endif
    chk("l2 final idle", 32'(req_ready[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
